sp_shadow_unit: RTL and testbench

- Parametrised speculative stack-pointer tracker in the decode stage; the next generation of the single-width virtual SP block.
- Keeps a shadow SP, forwards SP writes in flight from EX/MEM/WB, and applies push/pop adjustments with a configurable step.
- Adds bounds checking with a sticky fault, and a flush-driven resynchronisation state machine.
- Feeds the SP operand to address generation and the not-ready flag to the hazard unit.

---
 rtl/sp_shadow_unit.sv | 137 +++++++++++++
 tb/tb_sp_shadow_unit.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/sp_shadow_unit.sv
// Speculative stack-pointer tracker for the decode stage.
// Maintains a shadow SP with EX/MEM/WB bypass, push/pop stepping, and bounds faulting.
//
// state | meaning
// SYNC  | shadow not trusted; base value comes from the regfile SP
// TRACK | shadow follows decoded push/pop and bypassed writes
// HALT  | bounds fault latched; shadow frozen until flush or reset
module sp_shadow_unit #(
    parameter int unsigned     DW      = 8,
    parameter int unsigned     AW      = 2,
    parameter int unsigned     SP_IDX  = 3,
    parameter int unsigned     STEP    = 1,
    parameter logic [DW-1:0]   STK_TOP = 8'hFF,
    parameter logic [DW-1:0]   STK_LIM = 8'h80
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic [DW-1:0] rf_sp,
    input  logic [1:0]    sp_op,
    input  logic          ex_we,
    input  logic          mem_we,
    input  logic          wb_we,
    input  logic [AW-1:0] ex_wa,
    input  logic [AW-1:0] mem_wa,
    input  logic [AW-1:0] wb_wa,
    input  logic [1:0]    ex_src,
    input  logic [1:0]    mem_src,
    input  logic [DW-1:0] ex_data,
    input  logic [DW-1:0] mem_data,
    input  logic [DW-1:0] wb_data,
    output logic [DW-1:0] sp_out,
    output logic          not_ready,
    output logic          sp_fault,
    output logic [1:0]    fault_code,
    output logic          synced
);

    typedef enum logic [1:0] {
        SYNC  = 2'b00,
        TRACK = 2'b01,
        HALT  = 2'b10
    } state_t;

    localparam logic [AW-1:0] SP_A   = AW'(SP_IDX);
    localparam logic [DW:0]   STEP_X = (DW+1)'(STEP);
    localparam logic [DW:0]   LIM_X  = {1'b0, STK_LIM} + STEP_X;
    localparam logic [DW:0]   TOP_X  = {1'b0, STK_TOP};

    state_t          state, state_nxt;
    logic [DW-1:0]   shadow, shadow_nxt;
    logic            fault_nxt;
    logic [1:0]      code_nxt;

    logic            ex_hit, mem_hit, wb_hit;
    logic [DW-1:0]   base;
    logic            is_push, is_pop;
    logic [DW:0]     sum_push, sum_pop;
    logic            ovf, unf;

    assign ex_hit  = ex_we  && (ex_wa  == SP_A);
    assign mem_hit = mem_we && (mem_wa == SP_A);
    assign wb_hit  = wb_we  && (wb_wa  == SP_A);
    assign base    = (state == SYNC) ? rf_sp : shadow;

    // Only ALU results can be forwarded early; loads and port reads stall until WB.
    always_comb begin
        sp_out    = base;
        not_ready = 1'b0;
        if (ex_hit) begin
            if (ex_src == 2'b00) sp_out = ex_data;
            else                 not_ready = 1'b1;
        end else if (mem_hit) begin
            if (mem_src == 2'b00) sp_out = mem_data;
            else                  not_ready = 1'b1;
        end else if (wb_hit) begin
            sp_out = wb_data;
        end
    end

    assign is_push  = (sp_op == 2'b01);
    assign is_pop   = (sp_op == 2'b10);
    assign sum_push = {1'b0, sp_out} - STEP_X;
    assign sum_pop  = {1'b0, sp_out} + STEP_X;
    assign ovf      = is_push && (({1'b0, sp_out} < LIM_X) || sum_push[DW]);
    assign unf      = is_pop  && (sum_pop > TOP_X);

    always_comb begin
        state_nxt  = state;
        shadow_nxt = shadow;
        fault_nxt  = sp_fault;
        code_nxt   = fault_code;
        if (flush) begin
            state_nxt = SYNC;
            fault_nxt = 1'b0;
            code_nxt  = 2'b00;
        end else if (!not_ready) begin
            case (state)
                SYNC, TRACK: begin
                    if (ovf) begin
                        state_nxt = HALT;
                        fault_nxt = 1'b1;
                        code_nxt  = 2'b01;
                    end else if (unf) begin
                        state_nxt = HALT;
                        fault_nxt = 1'b1;
                        code_nxt  = 2'b10;
                    end else begin
                        state_nxt = TRACK;
                        if (is_push)     shadow_nxt = sum_push[DW-1:0];
                        else if (is_pop) shadow_nxt = sum_pop[DW-1:0];
                        else             shadow_nxt = sp_out;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= SYNC;
            shadow     <= STK_TOP;
            sp_fault   <= 1'b0;
            fault_code <= 2'b00;
        end else if (!stall) begin
            state      <= state_nxt;
            shadow     <= shadow_nxt;
            sp_fault   <= fault_nxt;
            fault_code <= code_nxt;
        end
    end

    assign synced = (state == TRACK);

endmodule

// File: tb/tb_sp_shadow_unit.sv
// Vector-table bench for sp_shadow_unit: combinational outputs checked before each edge,
// registered outputs queued as expectations and checked after the edge.
module tb_sp_shadow_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       stall, flush;
    logic [7:0] rf_sp;
    logic [1:0] sp_op;
    logic       ex_we, mem_we, wb_we;
    logic [1:0] ex_wa, mem_wa, wb_wa;
    logic [1:0] ex_src, mem_src;
    logic [7:0] ex_data, mem_data, wb_data;
    logic [7:0] sp_out;
    logic       not_ready, sp_fault, synced;
    logic [1:0] fault_code;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sp_shadow_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .rf_sp(rf_sp), .sp_op(sp_op),
        .ex_we(ex_we), .mem_we(mem_we), .wb_we(wb_we),
        .ex_wa(ex_wa), .mem_wa(mem_wa), .wb_wa(wb_wa),
        .ex_src(ex_src), .mem_src(mem_src),
        .ex_data(ex_data), .mem_data(mem_data), .wb_data(wb_data),
        .sp_out(sp_out), .not_ready(not_ready), .sp_fault(sp_fault),
        .fault_code(fault_code), .synced(synced)
    );

    typedef struct packed {
        logic       stall, flush;
        logic [7:0] rf;
        logic [1:0] op;
        logic       ex_we;  logic [1:0] ex_wa;  logic [1:0] ex_src;  logic [7:0] ex_d;
        logic       mem_we; logic [1:0] mem_wa; logic [1:0] mem_src; logic [7:0] mem_d;
        logic       wb_we;  logic [1:0] wb_wa;  logic [7:0] wb_d;
        logic [7:0] e_sp;
        logic       e_nr, e_sync, e_flt;
        logic [1:0] e_code;
    } vec_t;

    typedef struct packed {
        int         idx;
        logic       sync, flt;
        logic [1:0] code;
    } exp_t;

    localparam int NV = 31;
    vec_t tbl [NV];
    exp_t sb_q [$];

    task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        stall = v.stall; flush = v.flush; rf_sp = v.rf; sp_op = v.op;
        ex_we = v.ex_we; ex_wa = v.ex_wa; ex_src = v.ex_src; ex_data = v.ex_d;
        mem_we = v.mem_we; mem_wa = v.mem_wa; mem_src = v.mem_src; mem_data = v.mem_d;
        wb_we = v.wb_we; wb_wa = v.wb_wa; wb_data = v.wb_d;
    endtask

    initial begin
        exp_t e;
        vec_t idle;
        // stall flush rf op | ex we wa src d | mem we wa src d | wb we wa d | sp nr sync flt code
        tbl[0]  = '{1'b0,1'b0,8'hF0,2'b00, 1'b0,2'd0,2'd0,8'h00, 1'b0,2'd0,2'd0,8'h00, 1'b0,2'd0,8'h00, 8'hF0,1'b0,1'b1,1'b0,2'b00};
        tbl[1]  = '{1'b0,1'b1,8'hFF,2'b00, 1'b0,2'd0,2'd0,8'h00, 1'b0,2'd0,2'd0,8'h00, 1'b0,2'd0,8'h00, 8'hF0,1'b0,1'b0,1'b0,2'b00};
        tbl[2]  = '{1'b0,1'b0,8'hFF,2'b00, 1'b0,2'd0,2'd0,8'h00, 1'b0,2'd0,2'd0,8'h00, 1'b0,2'd0,8'h00, 8'hFF,1'b0,1'b1,1'b0,2'b00};
        tbl[3]  = '{1'b0,1'b0,8'h00,2'b01, 1'b0,2'd0,2'd0,8'h00, 1'b0,2'd0,2'd0,8'h00, 1'b0,2'd0,8'h00, 8'hFF,1'b0,1'b1,1'b0,2'b00};
        tbl[4]  = '{1'b0,1'b0,8'h00,2'b01, 1'b0,2'd0,2'd0,8'h00, 1'b0,2'd0,2'd0,8'h00, 1'b0,2'd0,8'h00, 8'hFE,1'b0,1'b1,1'b0,2'b00};
        tbl[5]  = '{1'b0,1'b0,8'h00,2'b01, 1'b0,2'd0,2'd0,8'h00, 1'b0,2'd0,2'd0,8'h00, 1'b0,2'd0,8'h00, 8'hFD,1'b0,1'b1,1'b0,2'b00};
        tbl[6]  = '{1'b0,1'b0,8'h00,2'b10, 1'b0,2'd0,2'd0,8'h00, 1'b0,2'd0,2'd0,8'h00, 1'b0,2'd0,8'h00, 8'hFC,1'b0,1'b1,1'b0,2'b00};
        tbl[7]  = '{1'b0,1'b0,8'h00,2'b00, 1'b0,2'd0,2'd0,8'h00, 1'b0,2'd0,2'd0,8'h00, 1'b0,2'd0,8'h00, 8'hFD,1'b0,1'b1,1'b0,2'b00};
        tbl[8]  = '{1'b0,1'b0,8'h00,2'b01, 1'b1,2'd3,2'd0,8'h90, 1'b1,2'd3,2'd0,8'hA0, 1'b0,2'd0,8'h00, 8'h90,1'b0,1'b1,1'b0,2'b00};
        tbl[9]  = '{1'b0,1'b0,8'h00,2'b00, 1'b0,2'd0,2'd0,8'h00, 1'b0,2'd0,2'd0,8'h00, 1'b0,2'd0,8'h00, 8'h8F,1'b0,1'b1,1'b0,2'b00};
        tbl[10] = '{1'b0,1'b0,8'h00,2'b00, 1'b1,2'd2,2'd0,8'h11, 1'b0,2'd0,2'd0,8'h00, 1'b1,2'd3,8'h55, 8'h55,1'b0,1'b1,1'b0,2'b00};
        tbl[11] = '{1'b1,1'b0,8'h00,2'b01, 1'b0,2'd0,2'd0,8'h00, 1'b1,2'd3,2'd1,8'h33, 1'b0,2'd0,8'h00, 8'h55,1'b1,1'b1,1'b0,2'b00};
        tbl[12] = '{1'b0,1'b0,8'h00,2'b01, 1'b0,2'd0,2'd0,8'h00, 1'b1,2'd3,2'd1,8'h33, 1'b0,2'd0,8'h00, 8'h55,1'b1,1'b1,1'b0,2'b00};
        tbl[13] = '{1'b0,1'b0,8'h00,2'b00, 1'b0,2'd0,2'd0,8'h00, 1'b0,2'd0,2'd0,8'h00, 1'b1,2'd3,8'hC4, 8'hC4,1'b0,1'b1,1'b0,2'b00};
        tbl[14] = '{1'b0,1'b0,8'h00,2'b01, 1'b1,2'd3,2'd2,8'h77, 1'b0,2'd0,2'd0,8'h00, 1'b0,2'd0,8'h00, 8'hC4,1'b1,1'b1,1'b0,2'b00};
        tbl[15] = '{1'b0,1'b0,8'h00,2'b10, 1'b0,2'd0,2'd0,8'h00, 1'b1,2'd3,2'd2,8'h66, 1'b0,2'd0,8'h00, 8'hC4,1'b1,1'b1,1'b0,2'b00};
        tbl[16] = '{1'b0,1'b0,8'h00,2'b00, 1'b0,2'd0,2'd0,8'h00, 1'b1,2'd3,2'd0,8'h81, 1'b0,2'd0,8'h00, 8'h81,1'b0,1'b1,1'b0,2'b00};
        tbl[17] = '{1'b0,1'b0,8'h00,2'b01, 1'b0,2'd0,2'd0,8'h00, 1'b0,2'd0,2'd0,8'h00, 1'b0,2'd0,8'h00, 8'h81,1'b0,1'b1,1'b0,2'b00};
        tbl[18] = '{1'b0,1'b0,8'h00,2'b01, 1'b0,2'd0,2'd0,8'h00, 1'b0,2'd0,2'd0,8'h00, 1'b0,2'd0,8'h00, 8'h80,1'b0,1'b0,1'b1,2'b01};
        tbl[19] = '{1'b0,1'b0,8'h00,2'b10, 1'b0,2'd0,2'd0,8'h00, 1'b0,2'd0,2'd0,8'h00, 1'b0,2'd0,8'h00, 8'h80,1'b0,1'b0,1'b1,2'b01};
        tbl[20] = '{1'b0,1'b1,8'hA5,2'b00, 1'b0,2'd0,2'd0,8'h00, 1'b0,2'd0,2'd0,8'h00, 1'b0,2'd0,8'h00, 8'h80,1'b0,1'b0,1'b0,2'b00};
        tbl[21] = '{1'b0,1'b0,8'hA5,2'b00, 1'b0,2'd0,2'd0,8'h00, 1'b0,2'd0,2'd0,8'h00, 1'b0,2'd0,8'h00, 8'hA5,1'b0,1'b1,1'b0,2'b00};
        tbl[22] = '{1'b0,1'b1,8'hFF,2'b00, 1'b0,2'd0,2'd0,8'h00, 1'b0,2'd0,2'd0,8'h00, 1'b0,2'd0,8'h00, 8'hA5,1'b0,1'b0,1'b0,2'b00};
        tbl[23] = '{1'b1,1'b0,8'hFF,2'b10, 1'b0,2'd0,2'd0,8'h00, 1'b0,2'd0,2'd0,8'h00, 1'b0,2'd0,8'h00, 8'hFF,1'b0,1'b0,1'b0,2'b00};
        tbl[24] = '{1'b0,1'b0,8'hFF,2'b10, 1'b0,2'd0,2'd0,8'h00, 1'b0,2'd0,2'd0,8'h00, 1'b0,2'd0,8'h00, 8'hFF,1'b0,1'b0,1'b1,2'b10};
        tbl[25] = '{1'b1,1'b1,8'hFF,2'b00, 1'b0,2'd0,2'd0,8'h00, 1'b0,2'd0,2'd0,8'h00, 1'b0,2'd0,8'h00, 8'hA5,1'b0,1'b0,1'b1,2'b10};
        tbl[26] = '{1'b0,1'b1,8'h90,2'b00, 1'b0,2'd0,2'd0,8'h00, 1'b0,2'd0,2'd0,8'h00, 1'b0,2'd0,8'h00, 8'hA5,1'b0,1'b0,1'b0,2'b00};
        tbl[27] = '{1'b0,1'b0,8'h90,2'b11, 1'b0,2'd0,2'd0,8'h00, 1'b0,2'd0,2'd0,8'h00, 1'b0,2'd0,8'h00, 8'h90,1'b0,1'b1,1'b0,2'b00};
        tbl[28] = '{1'b0,1'b0,8'h00,2'b00, 1'b0,2'd0,2'd0,8'h00, 1'b0,2'd0,2'd0,8'h00, 1'b0,2'd0,8'h00, 8'h90,1'b0,1'b1,1'b0,2'b00};
        tbl[29] = '{1'b0,1'b0,8'h00,2'b10, 1'b0,2'd0,2'd0,8'h00, 1'b1,2'd3,2'd0,8'h70, 1'b1,2'd3,8'h60, 8'h70,1'b0,1'b1,1'b0,2'b00};
        tbl[30] = '{1'b0,1'b0,8'h00,2'b00, 1'b0,2'd0,2'd0,8'h00, 1'b0,2'd0,2'd0,8'h00, 1'b0,2'd0,8'h00, 8'h71,1'b0,1'b1,1'b0,2'b00};

        idle = tbl[0];
        rst = 1'b0;
        drive(idle);
        #1;
        chk("rst_sp_out", -1, sp_out, 8'hF0);
        chk("rst_synced", -1, {7'd0, synced}, 8'h00);
        chk("rst_fault", -1, {7'd0, sp_fault}, 8'h00);
        chk("rst_code", -1, {6'd0, fault_code}, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i]);
            #1;
            chk("sp_out", i, sp_out, tbl[i].e_sp);
            chk("not_ready", i, {7'd0, not_ready}, {7'd0, tbl[i].e_nr});
            sb_q.push_back('{i, tbl[i].e_sync, tbl[i].e_flt, tbl[i].e_code});
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            chk("synced", e.idx, {7'd0, synced}, {7'd0, e.sync});
            chk("sp_fault", e.idx, {7'd0, sp_fault}, {7'd0, e.flt});
            chk("fault_code", e.idx, {6'd0, fault_code}, {6'd0, e.code});
            @(negedge clk);
        end

        // Shadow is 71 here: a push faults, then reset is asserted between edges.
        idle.rf = 8'h3C;
        idle.op = 2'b01;
        drive(idle);
        @(posedge clk);
        #1;
        chk("pre_rst_fault", 100, {7'd0, sp_fault}, 8'h01);
        chk("pre_rst_code", 100, {6'd0, fault_code}, 8'h01);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_fault", 101, {7'd0, sp_fault}, 8'h00);
        chk("async_rst_code", 101, {6'd0, fault_code}, 8'h00);
        chk("async_rst_sp", 101, sp_out, 8'h3C);
        @(negedge clk);
        rst = 1'b1;
        idle.op = 2'b00;
        drive(idle);
        @(posedge clk);
        #1;
        chk("post_rst_synced", 102, {7'd0, synced}, 8'h01);
        chk("post_rst_sp", 102, sp_out, 8'h3C);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
